// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and the captured request.
// Optional misalignment trapping is selected with DMEM_MISALIGN_TRAP_EN (see dmem_responder).
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } dmem_state_t;

    // size keeps the raw 2-bit code so the illegal value 2'b11 survives capture
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        mem_size_t   size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and store replication, load extraction and extension.
// Misaligned half/word addresses are force-aligned here; the top decides whether to trap them.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [1:0]  eff_lo;
    logic [31:0] shifted;

    always_comb begin
        eff_lo      = addr_lo;
        byte_en     = 4'b0000;
        wdata_lanes = wdata;
        rdata_ext   = 32'h0;
        misaligned  = 1'b0;
        shifted     = 32'h0;
        case (size)
            SZ_BYTE: begin
                eff_lo      = addr_lo;
                byte_en     = 4'b0001 << eff_lo;
                wdata_lanes = {4{wdata[7:0]}};
                shifted     = rword >> {eff_lo, 3'b000};
                rdata_ext   = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            end
            SZ_HALF: begin
                eff_lo      = {addr_lo[1], 1'b0};
                byte_en     = eff_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                shifted     = rword >> {eff_lo, 3'b000};
                rdata_ext   = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
                misaligned  = addr_lo[0];
            end
            SZ_WORD: begin
                eff_lo      = 2'b00;
                byte_en     = 4'b1111;
                rdata_ext   = rword;
                misaligned  = (addr_lo != 2'b00);
            end
            default: begin
                byte_en     = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: one request at a time, fixed latency, valid/ready on both sides.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_LAST  = 4'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic          illegal_size;
    logic          misaligned;
    logic          access_err;
    logic          cnt_done;
    logic          accept;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lanes;
    logic [31:0]   rdata_ext;

    assign offset       = req_q.addr - BASE_ADDR;
    assign word_idx     = offset[AW+1:2];
    assign out_of_range = ({1'b0, offset} >= SPAN);
    assign illegal_size = (req_q.size == mem_size_t'(2'b11));
`ifdef DMEM_MISALIGN_TRAP_EN
    assign access_err   = out_of_range | illegal_size | misaligned;
`else
    assign access_err   = out_of_range | illegal_size;
`endif
    assign cnt_done     = (cnt_q == CNT_LAST);
    assign accept       = (state_q == S_IDLE) && req_valid;

    dmem_lane_align u_align (
        .addr_lo     (req_q.addr[1:0]),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .rword       (rd_word_q),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (accept) begin
                    state_d = S_WAIT;
                    req_d   = '{we: req_we, addr: req_addr, size: mem_size_t'(req_size),
                                is_unsigned: req_unsigned, wdata: req_wdata};
                end
            end
            S_WAIT: begin
                if (cnt_done) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_err   = (state_q == S_RESP) && access_err;
        rsp_rdata = 32'h0;
        if ((state_q == S_RESP) && !req_q.we && !access_err) begin
            rsp_rdata = rdata_ext;
        end
    end

    // Storage is not reset; the rst term keeps a reset edge from committing a pending store
    always_ff @(posedge clk) begin
        if ((state_q == S_WAIT) && cnt_done && !rst) begin
            if (req_q.we && !access_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                    end
                end
            end
            rd_word_q <= mem[word_idx];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores/loads with hand-computed results, stall, range and reset cases.
// Misaligned-half expectations follow DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;

    localparam int LATENCY = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fails  = 0;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .LATENCY     (LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Issues one request from IDLE (called #1 after a rising edge); holds rsp_ready low for stall cycles.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input int stall,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        logic [31:0] held;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(LATENCY));
        held = rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            // a competing store during the stall must be ignored
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_wdata = 32'h0BAD_0BAD;
            @(posedge clk); #1;
            check({tag, " stall valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, " stall ready"}, {31'd0, req_ready}, 32'd0);
            check({tag, " stall rdata"}, rsp_rdata, held);
        end
        req_valid = 1'b0;
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {rsp_rdata[29:0], rsp_err, rsp_valid} ^ {30'd0, 1'b0, 1'b0}, 32'd0);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        txn("st word 0x10",   1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 32'h0,         1'b0);
        txn("ld word 0x10",   1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         0, 32'hDEAD_BEEF, 1'b0);
        txn("st word base",   1'b1, 32'h10, 2'b10, 1'b0, 32'h1122_3344, 0, 32'h0,         1'b0);
        txn("st byte 0x13",   1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_0080, 0, 32'h0,         1'b0);
        txn("ld sbyte 0x13",  1'b0, 32'h13, 2'b00, 1'b0, 32'h0,         0, 32'hFFFF_FF80, 1'b0);
        txn("ld ubyte 0x13",  1'b0, 32'h13, 2'b00, 1'b1, 32'h0,         0, 32'h0000_0080, 1'b0);
        txn("ld word 0x10b",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         0, 32'h8022_3344, 1'b0);
        txn("ld stall 0x10",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         3, 32'h8022_3344, 1'b0);
        txn("ld after stall", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         0, 32'h8022_3344, 1'b0);

        txn("st word 0x0",    1'b1, 32'h0,  2'b10, 1'b0, 32'h8001_7FFF, 0, 32'h0,         1'b0);
        txn("ld shalf 0x2",   1'b0, 32'h2,  2'b01, 1'b0, 32'h0,         0, 32'hFFFF_8001, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        txn("ld shalf 0x1",   1'b0, 32'h1,  2'b01, 1'b0, 32'h0,         0, 32'h0,         1'b1);
`else
        txn("ld shalf 0x1",   1'b0, 32'h1,  2'b01, 1'b0, 32'h0,         0, 32'h0000_7FFF, 1'b0);
`endif
        txn("st out of range", 1'b1, 32'h1000, 2'b10, 1'b0, 32'hCAFE_BABE, 0, 32'h0,      1'b1);
        txn("ld out of range", 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0,        0, 32'h0,       1'b1);
        txn("ld word 0 kept",  1'b0, 32'h0,    2'b10, 1'b0, 32'h0,        0, 32'h8001_7FFF, 1'b0);
        txn("st size 11",      1'b1, 32'h0,    2'b11, 1'b0, 32'h1234_5678, 0, 32'h0,      1'b1);
        txn("ld word 0 again", 1'b0, 32'h0,    2'b10, 1'b0, 32'h0,        0, 32'h8001_7FFF, 1'b0);

        txn("st word 0x20",   1'b1, 32'h20, 2'b10, 1'b0, 32'hA5A5_A5A5, 0, 32'h0,         1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_size  = 2'b10;
        req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst mid-wait", {30'd0, rsp_valid, req_ready}, 32'd1);
        txn("ld 0x20 old",    1'b0, 32'h20, 2'b10, 1'b0, 32'h0,         0, 32'hA5A5_A5A5, 1'b0);
        txn("st half 0x22",   1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_BEEF, 0, 32'h0,         1'b0);
        txn("ld word 0x20",   1'b0, 32'h20, 2'b10, 1'b0, 32'h0,         0, 32'hBEEF_A5A5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
